// File: rtl/meikyuu_vga_pkg.sv
// Shared 640x480@60 raster timing, mixer colours and collision FSM encoding.
// Bar helper exists only when VGA_TEST_PATTERN_EN is defined.
package meikyuu_vga_pkg;
  localparam int H_SYNC   = 96;
  localparam int H_BACK   = 48;
  localparam int H_ACTIVE = 640;
  localparam int H_FRONT  = 16;
  localparam int V_SYNC   = 2;
  localparam int V_BACK   = 33;
  localparam int V_ACTIVE = 480;
  localparam int V_FRONT  = 10;

  localparam int ACTIVE_X0 = H_SYNC + H_BACK;
  localparam int ACTIVE_Y0 = V_SYNC + V_BACK;

  typedef logic [23:0] rgb_t;

  localparam rgb_t PLAYER_RGB = 24'hFFD000;
  localparam rgb_t WALL_RGB   = 24'h3050C0;
  localparam rgb_t BG_RGB     = 24'h000000;

  typedef enum logic {
    SCAN  = 1'b0,
    LATCH = 1'b1
  } coll_state_e;

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = 80;

  function automatic rgb_t bar_rgb(logic [9:0] xoff);
    logic [2:0] idx;
    idx = 3'(xoff / 10'(BAR_W));
    return {{8{idx[2]}}, {8{idx[1]}}, {8{idx[0]}}};
  endfunction
`endif
endpackage

// File: rtl/vga_scan_mixer_if.sv
// Scan bus between the raster/mixer and the sprite blocks plus the VGA pins.
// test_mode exists only when VGA_TEST_PATTERN_EN is defined.
interface vga_scan_mixer_if;
  logic       player_draw;
  logic       wall_draw;
  logic [9:0] h_counter;
  logic [9:0] v_counter;
  logic       vga_hs;
  logic       vga_vs;
  logic       vga_blank_n;
  logic       vga_sync_n;
  logic [7:0] vga_r;
  logic [7:0] vga_g;
  logic [7:0] vga_b;
  logic       frame_end;
  logic       collision;
`ifdef VGA_TEST_PATTERN_EN
  logic       test_mode;
`endif

  modport master (
`ifdef VGA_TEST_PATTERN_EN
    input  test_mode,
`endif
    input  player_draw, wall_draw,
    output h_counter, v_counter,
    output vga_hs, vga_vs,
    output vga_blank_n, vga_sync_n,
    output vga_r, vga_g, vga_b,
    output frame_end, collision
  );

  modport slave (
`ifdef VGA_TEST_PATTERN_EN
    output test_mode,
`endif
    output player_draw, wall_draw,
    input  h_counter, v_counter,
    input  vga_hs, vga_vs,
    input  vga_blank_n, vga_sync_n,
    input  vga_r, vga_g, vga_b,
    input  frame_end, collision
  );
endinterface

// File: rtl/vga_raster_counter.sv
// Registered h/v raster counters with wrap, active-window and sync decode.
module vga_raster_counter
  import meikyuu_vga_pkg::*;
#(
  parameter int H_SYNC_W  = H_SYNC,
  parameter int H_BACK_W  = H_BACK,
  parameter int H_ACT_W   = H_ACTIVE,
  parameter int H_FRONT_W = H_FRONT,
  parameter int V_SYNC_W  = V_SYNC,
  parameter int V_BACK_W  = V_BACK,
  parameter int V_ACT_W   = V_ACTIVE,
  parameter int V_FRONT_W = V_FRONT
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] h,
  output logic [9:0] v,
  output logic       active,
  output logic       in_hsync,
  output logic       in_vsync,
  output logic       frame_last
);
  localparam int HT = H_SYNC_W + H_BACK_W + H_ACT_W + H_FRONT_W;
  localparam int VT = V_SYNC_W + V_BACK_W + V_ACT_W + V_FRONT_W;

  localparam logic [9:0] H_LAST = 10'(HT - 1);
  localparam logic [9:0] V_LAST = 10'(VT - 1);
  localparam logic [9:0] X0 = 10'(H_SYNC_W + H_BACK_W);
  localparam logic [9:0] X1 = 10'(H_SYNC_W + H_BACK_W + H_ACT_W - 1);
  localparam logic [9:0] Y0 = 10'(V_SYNC_W + V_BACK_W);
  localparam logic [9:0] Y1 = 10'(V_SYNC_W + V_BACK_W + V_ACT_W - 1);

  logic line_last;

  assign line_last  = (h == H_LAST);
  assign frame_last = line_last && (v == V_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (line_last) begin
      h <= '0;
      v <= frame_last ? '0 : v + 10'd1;
    end else begin
      h <= h + 10'd1;
    end
  end

  assign active = (h >= X0) && (h <= X1) &&
                  (v >= Y0) && (v <= Y1);

  assign in_hsync = (h < 10'(H_SYNC_W));
  assign in_vsync = (v < 10'(V_SYNC_W));
endmodule

// File: rtl/vga_scan_mixer.sv
// VGA raster, one-stage colour/sync mixer and per-frame collision latch.
// Optional VGA_TEST_PATTERN_EN adds test_mode colour bars.
module vga_scan_mixer
  import meikyuu_vga_pkg::*;
#(
  parameter int H_SYNC_W  = H_SYNC,
  parameter int H_BACK_W  = H_BACK,
  parameter int H_ACT_W   = H_ACTIVE,
  parameter int H_FRONT_W = H_FRONT,
  parameter int V_SYNC_W  = V_SYNC,
  parameter int V_BACK_W  = V_BACK,
  parameter int V_ACT_W   = V_ACTIVE,
  parameter int V_FRONT_W = V_FRONT
) (
  input logic             CLOCK_25,
  input logic             reset,
  vga_scan_mixer_if.master bus
);
  logic [9:0] h;
  logic [9:0] v;
  logic       active;
  logic       in_hsync;
  logic       in_vsync;
  logic       frame_last;

  vga_raster_counter #(
    .H_SYNC_W (H_SYNC_W),
    .H_BACK_W (H_BACK_W),
    .H_ACT_W  (H_ACT_W),
    .H_FRONT_W(H_FRONT_W),
    .V_SYNC_W (V_SYNC_W),
    .V_BACK_W (V_BACK_W),
    .V_ACT_W  (V_ACT_W),
    .V_FRONT_W(V_FRONT_W)
  ) u_raster (
    .clk       (CLOCK_25),
    .rst       (reset),
    .h         (h),
    .v         (v),
    .active    (active),
    .in_hsync  (in_hsync),
    .in_vsync  (in_vsync),
    .frame_last(frame_last)
  );

  assign bus.h_counter = h;
  assign bus.v_counter = v;

  rgb_t pix;
  rgb_t rgb_q;
  logic hs_q;
  logic vs_q;
  logic blank_n_q;

  // Out-of-window draw flags are sprite garbage and must never colour a pixel
  always_comb begin
    pix = BG_RGB;
    if (!active)
      pix = '0;
`ifdef VGA_TEST_PATTERN_EN
    else if (bus.test_mode)
      pix = bar_rgb(h - 10'(H_SYNC_W + H_BACK_W));
`endif
    else if (bus.player_draw)
      pix = PLAYER_RGB;
    else if (bus.wall_draw)
      pix = WALL_RGB;
  end

  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
      rgb_q     <= '0;
    end else begin
      hs_q      <= ~in_hsync;
      vs_q      <= ~in_vsync;
      blank_n_q <= active;
      rgb_q     <= pix;
    end
  end

  assign bus.vga_hs      = hs_q;
  assign bus.vga_vs      = vs_q;
  assign bus.vga_blank_n = blank_n_q;
  assign bus.vga_sync_n  = 1'b0;
  assign bus.vga_r       = rgb_q[23:16];
  assign bus.vga_g       = rgb_q[15:8];
  assign bus.vga_b       = rgb_q[7:0];

  coll_state_e state_q, state_d;
  logic        hit_q, hit_d;
  logic        coll_q, coll_d;
  logic        fe_q, fe_d;

  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      state_q <= SCAN;
      hit_q   <= 1'b0;
      coll_q  <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hit_q   <= hit_d;
      coll_q  <= coll_d;
      fe_q    <= fe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hit_d   = hit_q;
    coll_d  = coll_q;
    fe_d    = 1'b0;
    unique case (state_q)
      SCAN: begin
        hit_d = hit_q | (bus.player_draw & bus.wall_draw & active);
        if (frame_last)
          state_d = LATCH;
      end
      LATCH: begin
        coll_d  = hit_q;
        fe_d    = 1'b1;
        hit_d   = 1'b0;
        state_d = SCAN;
      end
      default: state_d = SCAN;
    endcase
  end

  assign bus.collision = coll_q;
  assign bus.frame_end = fe_q;
endmodule

// File: tb/tb_vga_scan_mixer.sv
// Randomised bench for vga_scan_mixer on a shrunken raster.
// Reference model derives every output from the cycle count since reset.
module tb_vga_scan_mixer;
  import meikyuu_vga_pkg::*;

  localparam int HS = 8;
  localparam int HB = 4;
  localparam int HA = 40;
  localparam int HF = 4;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int VA = 20;
  localparam int VF = 2;
  localparam int HT = HS + HB + HA + HF;
  localparam int VT = VS + VB + VA + VF;
  localparam int FT = HT * VT;
  localparam int X0 = HS + HB;
  localparam int X1 = X0 + HA - 1;
  localparam int Y0 = VS + VB;
  localparam int Y1 = Y0 + VA - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #20 clk = ~clk;

  vga_scan_mixer_if bus();

  vga_scan_mixer #(
    .H_SYNC_W (HS),
    .H_BACK_W (HB),
    .H_ACT_W  (HA),
    .H_FRONT_W(HF),
    .V_SYNC_W (VS),
    .V_BACK_W (VB),
    .V_ACT_W  (VA),
    .V_FRONT_W(VF)
  ) dut (
    .CLOCK_25(clk),
    .reset   (rst),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int n;
  bit frame_hit[int];
  bit last_p;
  bit last_w;
  int mode;
  int tx;
  int ty;
  int fe_seen;
  int vs_low;

  function automatic bit in_win(int h, int v);
    return h >= X0 && h <= X1 && v >= Y0 && v <= Y1;
  endfunction

  function automatic logic [23:0] colour(int h, int v, bit p, bit w);
    if (!in_win(h, v)) return 24'h0;
    if (p) return PLAYER_RGB;
    if (w) return WALL_RGB;
    return BG_RGB;
  endfunction

  task automatic check_outputs();
    int pos, h, v, pp, ph, pv, f;
    logic [26:0] exp_pix;
    bit fe, col;
    pos = n % FT;
    h = pos % HT;
    v = pos / HT;
    chk("counters", {bus.h_counter, bus.v_counter},
        {10'(h), 10'(v)});
    if (n == 0) begin
      exp_pix = {1'b1, 1'b1, 1'b0, 24'h0};
    end else begin
      pp = (n - 1) % FT;
      ph = pp % HT;
      pv = pp / HT;
      exp_pix = {ph >= HS, pv >= VS, in_win(ph, pv),
                 colour(ph, pv, last_p, last_w)};
      if (mode == 0 && ph == X0 && pv == Y0)
        chk("first_pixel", {bus.vga_blank_n, bus.vga_r,
            bus.vga_g, bus.vga_b}, {1'b1, 24'hFFD000});
      if (ph == X0 - 1 && pv == Y0)
        chk("pre_window", {bus.vga_blank_n, bus.vga_r,
            bus.vga_g, bus.vga_b}, 25'h0);
    end
    chk("pixel", {bus.vga_hs, bus.vga_vs, bus.vga_blank_n,
        bus.vga_r, bus.vga_g, bus.vga_b}, exp_pix);
    fe = 1'b0;
    col = 1'b0;
    if (n >= 1) begin
      fe = (n > FT) && ((n - 1) % FT == 0);
      f = (n - 1) / FT - 1;
      col = (f >= 0) ? frame_hit.exists(f) : 1'b0;
    end
    chk("frame_end_coll", {bus.frame_end, bus.collision,
        bus.vga_sync_n}, {fe, col, 1'b0});
    if (bus.frame_end) fe_seen++;
    if (!bus.vga_vs) vs_low++;
  endtask

  task automatic drive();
    int pos, h, v;
    bit p, w;
    pos = n % FT;
    h = pos % HT;
    v = pos / HT;
    p = ($urandom % 4) == 0;
    w = ($urandom % 3) == 0;
    if (mode == 0 && in_win(h, v) && p && w) w = 1'b0;
    if (mode == 0 && h == X0 && v == Y0) begin
      p = 1'b1;
      w = 1'b0;
    end
    if (h == X0 - 1 && v == Y0) begin
      p = 1'b1;
      w = 1'b1;
    end
    if (h == tx && v == ty) begin
      p = 1'b1;
      w = 1'b1;
    end
    bus.player_draw = p;
    bus.wall_draw = w;
    if (in_win(h, v) && p && w) frame_hit[n / FT] = 1'b1;
    last_p = p;
    last_w = w;
  endtask

  task automatic run(int cycles);
    repeat (cycles) begin
      check_outputs();
      drive();
      @(posedge clk);
      n++;
      @(negedge clk);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.player_draw = 1'b0;
    bus.wall_draw = 1'b0;
    #1;
    chk("reset_counters", {bus.h_counter, bus.v_counter}, 20'h0);
    chk("reset_state", {bus.collision, bus.frame_end, bus.vga_hs,
        bus.vga_vs, bus.vga_blank_n, bus.vga_r, bus.vga_g,
        bus.vga_b}, {4'b0011, 25'h0});
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    frame_hit.delete();
  endtask

  initial begin
    bus.player_draw = 1'b0;
    bus.wall_draw = 1'b0;
`ifdef VGA_TEST_PATTERN_EN
    bus.test_mode = 1'b0;
`endif
    mode = 0;
    tx = -1;
    ty = -1;
    fe_seen = 0;
    vs_low = 0;
    n = 0;
    @(negedge clk);
    apply_reset();

    run(FT);
    chk("vs_low_clocks", 64'(vs_low), 64'(VS * HT));
    tx = 30; ty = 12;
    run(FT);
    tx = -1; ty = -1;
    run(FT);
    tx = 2; ty = 2;
    run(FT);
    tx = -1; ty = -1;
    run(FT);
    tx = 20; ty = 8;
    run(15 * HT + 35);
    apply_reset();

    tx = -1; ty = -1;
    run(FT);
    run(FT);
    mode = 1;
    run(FT);
    mode = 0;
    run(FT + 2);
    chk("frame_end_pulses", 64'(fe_seen), 64'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
